// File: rtl/genomics_result_unpacker.sv
// genomics_result_unpacker: accepts wide result lines and serialises them into LSB-first words.
// Defining GENOMICS_UNPACK_PREFETCH_EN adds a one-line prefetch buffer and registers in_ready.
module genomics_result_unpacker #(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_ready,
  input  logic                    in_avail,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_avail,
  output logic [C_WORD_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [31:0]             lines_done
);

  localparam int N  = C_DATA_WIDTH / C_WORD_WIDTH;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [C_DATA_WIDTH-1:0] line_q, line_d;
  logic [31:0]             lines_done_q, lines_done_d;
  logic                    last_word_s;
  logic                    word_xfer_s;
  logic                    line_xfer_s;

`ifdef GENOMICS_UNPACK_PREFETCH_EN
  logic [C_DATA_WIDTH-1:0] pf_q, pf_d;
  logic                    pf_valid_q, pf_valid_d;

  // in_ready depends only on the prefetch flag, so out_ready never reaches it.
  assign in_ready = ~reset & ~pf_valid_q;
`else
  assign in_ready = ~reset & ((state_q == EMPTY) |
                              ((state_q == DRAIN) & last_word_s & out_ready));
`endif

  assign last_word_s = (idx_q == LAST_IDX);
  assign word_xfer_s = (state_q == DRAIN) & out_ready;
  assign line_xfer_s = in_ready & in_avail;

  assign out_avail  = (state_q == DRAIN);
  assign out_data   = C_WORD_WIDTH'(line_q >> (int'(idx_q) * C_WORD_WIDTH));
  assign out_last   = (state_q == DRAIN) & last_word_s;
  assign lines_done = lines_done_q;

  // Next-state: word stepping, line reload at end of line, completed-line counting.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    line_d       = line_q;
    lines_done_d = lines_done_q;
`ifdef GENOMICS_UNPACK_PREFETCH_EN
    pf_d         = pf_q;
    pf_valid_d   = pf_valid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (line_xfer_s) begin
          line_d  = in_data;
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          state_d = EMPTY;
        end
      end
      DRAIN: begin
`ifdef GENOMICS_UNPACK_PREFETCH_EN
        if (line_xfer_s) begin
          pf_d       = in_data;
          pf_valid_d = 1'b1;
        end else begin
          pf_d = pf_q;
        end
`endif
        if (word_xfer_s && !last_word_s) begin
          idx_d = idx_q + IW'(1);
        end else if (word_xfer_s) begin
          lines_done_d = lines_done_q + 32'd1;
          idx_d        = '0;
`ifdef GENOMICS_UNPACK_PREFETCH_EN
          // A buffered line always precedes one arriving this cycle.
          if (pf_valid_q) begin
            line_d     = pf_q;
            pf_valid_d = line_xfer_s;
          end else if (line_xfer_s) begin
            line_d     = in_data;
            pf_valid_d = 1'b0;
          end else begin
            state_d = EMPTY;
          end
`else
          if (line_xfer_s) begin
            line_d = in_data;
          end else begin
            state_d = EMPTY;
          end
`endif
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any partially drained line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      idx_q        <= '0;
      line_q       <= '0;
      lines_done_q <= 32'd0;
`ifdef GENOMICS_UNPACK_PREFETCH_EN
      pf_q         <= '0;
      pf_valid_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      line_q       <= line_d;
      lines_done_q <= lines_done_d;
`ifdef GENOMICS_UNPACK_PREFETCH_EN
      pf_q         <= pf_d;
      pf_valid_q   <= pf_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_genomics_result_unpacker.sv
// Self-checking bench for genomics_result_unpacker: directed scenarios plus a
// randomized run against a word-queue reference model.
module tb_genomics_result_unpacker;

  localparam int DW = 512;
  localparam int WW = 32;
  localparam int N  = DW / WW;
`ifdef GENOMICS_UNPACK_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_ready;
  logic          in_avail;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_avail;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic [31:0]   lines_done;

  int          checks;
  int          errors;
  logic [31:0] exp_done;

  genomics_result_unpacker #(.C_DATA_WIDTH(DW), .C_WORD_WIDTH(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_avail  (in_avail),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_avail (out_avail),
    .out_data  (out_data),
    .out_last  (out_last),
    .lines_done(lines_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] make_line(input logic [31:0] base);
    logic [DW-1:0] l;
    l = '0;
    for (int k = 0; k < N; k++) l[k*WW +: WW] = base + 32'(k);
    return l;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    l = '0;
    for (int k = 0; k < N; k++) l[k*WW +: WW] = $urandom;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_avail = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_avail !== 1'b0) begin errors++; $display("FAIL reset_out_avail: got %b expected 0", out_avail); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (lines_done !== 32'h0) begin errors++; $display("FAIL reset_lines_done: got %h expected 0", lines_done); end
    tick();
    reset = 1'b0;
    exp_done = 32'd0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    tick();
  endtask

  task automatic test_single_line();
    logic [31:0] w;
    in_data = make_line(32'h1000); in_avail = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", in_ready); end
    tick();
    in_avail = 1'b0;
    for (int k = 0; k < N; k++) begin
      w = 32'h1000 + 32'(k);
      @(negedge clk);
      checks++; if (out_avail !== 1'b1 || out_data !== w || out_last !== (k == N-1))
        begin errors++; $display("FAIL single_word%0d: got avail=%b data=%h last=%b expected 1 %h %b", k, out_avail, out_data, out_last, w, (k == N-1)); end
      tick();
    end
    exp_done++;
    @(negedge clk);
    checks++; if (out_avail !== 1'b0 || in_ready !== 1'b1 || lines_done !== exp_done)
      begin errors++; $display("FAIL single_end: got avail=%b rdy=%b done=%0d expected 0 1 %0d", out_avail, in_ready, lines_done, exp_done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic        rdy;
    bit          l2_sent;
    l2_sent = 1'b0;
    in_data = make_line(32'h1000); in_avail = 1'b1; out_ready = 1'b1;
    tick();
    in_data = make_line(32'h2000);
    for (int k = 0; k < 2*N; k++) begin
      w   = (k < N) ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k - N);
      rdy = PF ? (k == 0 || k >= N) : ((k % N) == N-1);
      @(negedge clk);
      checks++; if (out_avail !== 1'b1 || out_data !== w || out_last !== ((k % N) == N-1) || in_ready !== rdy)
        begin errors++; $display("FAIL b2b_word%0d: got avail=%b data=%h last=%b rdy=%b expected 1 %h %b %b", k, out_avail, out_data, out_last, in_ready, w, ((k % N) == N-1), rdy); end
      if (in_avail && rdy) l2_sent = 1'b1;
      tick();
      if (l2_sent) in_avail = 1'b0;
    end
    exp_done += 32'd2;
    @(negedge clk);
    checks++; if (out_avail !== 1'b0 || lines_done !== exp_done)
      begin errors++; $display("FAIL b2b_end: got avail=%b done=%0d expected 0 %0d", out_avail, lines_done, exp_done); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] w;
    int          k;
    int          cyc;
    k = 0; cyc = 0;
    in_data = make_line(32'h1000); in_avail = 1'b1; out_ready = 1'b0;
    tick();
    in_avail = 1'b0;
    while (k < N && cyc < 100) begin
      out_ready = ((cyc % 3) == 0);
      w = 32'h1000 + 32'(k);
      @(negedge clk);
      checks++; if (out_avail !== 1'b1 || out_data !== w || out_last !== (k == N-1))
        begin errors++; $display("FAIL stall_cyc%0d: got avail=%b data=%h last=%b expected 1 %h %b", cyc, out_avail, out_data, out_last, w, (k == N-1)); end
      if (out_ready) k++;
      cyc++;
      tick();
    end
    checks++; if (k != N) begin errors++; $display("FAIL stall_timeout: got %0d words expected %0d", k, N); end
    exp_done++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_avail !== 1'b0 || lines_done !== exp_done)
      begin errors++; $display("FAIL stall_end: got avail=%b done=%0d expected 0 %0d", out_avail, lines_done, exp_done); end
    tick();
  endtask

  task automatic test_reset_mid_line();
    logic [31:0] w;
    in_data = make_line(32'h1000); in_avail = 1'b1; out_ready = 1'b1;
    tick();
    in_avail = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    #1;
    exp_done = 32'd0;
    checks++; if (out_avail !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0 || lines_done !== 32'h0)
      begin errors++; $display("FAIL midreset: got avail=%b last=%b data=%h done=%0d expected 0 0 0 0", out_avail, out_last, out_data, lines_done); end
    tick();
    reset = 1'b0;
    in_data = make_line(32'hA500_0000); in_avail = 1'b1;
    tick();
    in_avail = 1'b0;
    for (int k = 0; k < N; k++) begin
      w = 32'hA500_0000 + 32'(k);
      @(negedge clk);
      checks++; if (out_avail !== 1'b1 || out_data !== w || out_last !== (k == N-1))
        begin errors++; $display("FAIL midreset_word%0d: got avail=%b data=%h last=%b expected 1 %h %b", k, out_avail, out_data, out_last, w, (k == N-1)); end
      tick();
    end
    exp_done++;
    @(negedge clk);
    checks++; if (lines_done !== exp_done) begin errors++; $display("FAIL midreset_done: got %0d expected %0d", lines_done, exp_done); end
    tick();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.lines_done_q = 32'hFFFF_FFFF;
    #1;
    release dut.lines_done_q;
    exp_done = 32'hFFFF_FFFF;
    in_data = make_line(32'h7000); in_avail = 1'b1; out_ready = 1'b1;
    tick();
    in_avail = 1'b0;
    for (int k = 0; k < N; k++) tick();
    exp_done++;
    @(negedge clk);
    checks++; if (lines_done !== exp_done || lines_done !== 32'h0)
      begin errors++; $display("FAIL wrap: got %h expected %h", lines_done, exp_done); end
    tick();
  endtask

  task automatic test_prefetch_fill();
    int          acc;
    int          nexp;
    logic [31:0] w;
    acc = 0;
    nexp = PF ? 2 : 1;
    out_ready = 1'b0; in_avail = 1'b1; in_data = make_line(32'h3000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready && in_avail) acc++;
      tick();
      in_data = make_line(32'h3000 + 32'(acc) * 32'h1000);
    end
    @(negedge clk);
    checks++; if (acc != nexp) begin errors++; $display("FAIL fill_accepted: got %0d expected %0d", acc, nexp); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    tick();
    in_avail = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < nexp*N; k++) begin
      w = 32'h3000 + 32'(k / N) * 32'h1000 + 32'(k % N);
      @(negedge clk);
      checks++; if (out_avail !== 1'b1 || out_data !== w || out_last !== ((k % N) == N-1))
        begin errors++; $display("FAIL fill_word%0d: got avail=%b data=%h last=%b expected 1 %h %b", k, out_avail, out_data, out_last, w, ((k % N) == N-1)); end
      tick();
    end
    exp_done += 32'(nexp);
    @(negedge clk);
    checks++; if (out_avail !== 1'b0 || lines_done !== exp_done)
      begin errors++; $display("FAIL fill_end: got avail=%b done=%0d expected 0 %0d", out_avail, lines_done, exp_done); end
    tick();
  endtask

  // Reference: a FIFO of pending words; the block may hold one line (two with prefetch).
  task automatic test_random();
    logic [31:0] wq[$];
    bit          lq[$];
    logic        exp_rdy;
    bit          wx;
    bit          lx;
    bit          popped_last;
    in_avail = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_rdy = PF ? (wq.size() <= N) : (wq.size() == 0 || (wq.size() == 1 && out_ready));
      checks++; if (out_avail !== (wq.size() != 0)) begin errors++; $display("FAIL rand_avail c%0d: got %b expected %b", c, out_avail, (wq.size() != 0)); end
      if (wq.size() != 0) begin
        checks++; if (out_data !== wq[0] || out_last !== lq[0])
          begin errors++; $display("FAIL rand_word c%0d: got %h last=%b expected %h last=%b", c, out_data, out_last, wq[0], lq[0]); end
      end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      checks++; if (lines_done !== exp_done) begin errors++; $display("FAIL rand_done c%0d: got %0d expected %0d", c, lines_done, exp_done); end
      wx = (wq.size() != 0) && out_ready;
      lx = exp_rdy && in_avail;
      if (wx) begin
        popped_last = lq.pop_front();
        void'(wq.pop_front());
        if (popped_last) exp_done++;
      end
      if (lx) begin
        for (int k = 0; k < N; k++) begin
          wq.push_back(in_data[k*WW +: WW]);
          lq.push_back(k == N-1);
        end
      end
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_avail || lx) begin
        in_avail = $urandom_range(0, 1) == 1;
        in_data  = rand_line();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_done = 32'd0;
    test_reset();
    test_single_line();
    test_back_to_back();
    test_stall();
    test_reset_mid_line();
    test_wrap();
    test_prefetch_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/genomics_result_unpacker.md
Name: genomics_result_unpacker

Overview:
- Stream consumer at the output end of the genomics kernel: accepts C_DATA_WIDTH-bit result lines via ready/avail handshake and serialises each into C_WORD_WIDTH-bit words, LSB word first.
- Feeds narrow downstream logic (result writer / host word FIFO); tags last word of each line; counts completed lines.

Parameters:
- C_DATA_WIDTH, 512, input line width; must be integer multiple of C_WORD_WIDTH.
- C_WORD_WIDTH, 32, output word width; N = C_DATA_WIDTH/C_WORD_WIDTH words per line; N >= 2.

Ports:
- clk  input  1  sole clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_ready  output  1  block can take a line this cycle
- in_avail  input  1  upstream line valid
- in_data  input  C_DATA_WIDTH  upstream line
- out_ready  input  1  downstream accepts word
- out_avail  output  1  out_data valid
- out_data  output  C_WORD_WIDTH  current word
- out_last  output  1  current word is word N-1 of its line
- lines_done  output  32  completed lines, wraps modulo 2^32

Behaviour:
- Handshake: line transfer when in_ready & in_avail; word transfer when out_avail & out_ready. in_data is sampled only on a line transfer. out_data, out_last stable while out_avail=1 and out_ready=0.
- State: line register, word index idx (0..N-1), FSM {EMPTY, DRAIN}.
- Reset (async): FSM=EMPTY, idx=0, lines_done=0, line register=0. Outputs during and after reset: out_avail=0, out_last=0, out_data=0. in_ready=0 while reset asserted; 1 in the first cycle after deassertion.
- EMPTY: in_ready=1, out_avail=0. On line transfer: load line, idx=0, go DRAIN. Latency: word 0 presented on the cycle after line acceptance.
- DRAIN: out_avail=1, out_data=line[idx*C_WORD_WIDTH +: C_WORD_WIDTH], out_last=(idx==N-1).
  - Word transfer with idx<N-1: idx++.
  - Word transfer with idx==N-1: lines_done++ (wraps 0xFFFFFFFF->0).
    - If in_avail=1 in the same cycle: load new line, idx=0, stay DRAIN. No bubble; throughput 1 word/cycle sustained.
    - Otherwise: go EMPTY.
- Base in_ready = (FSM==EMPTY) | (FSM==DRAIN & idx==N-1 & out_ready). This is a combinational out_ready->in_ready path.
- in_avail while DRAIN and not on the last word: ignored, no load; upstream holds its line.
- out_ready=0 indefinitely: all state frozen, no words lost.
- Reset mid-line: remaining words discarded, lines_done cleared, no partial-line count.

Optional Feature:
- Macro GENOMICS_UNPACK_PREFETCH_EN.
  - Defined: adds one C_DATA_WIDTH prefetch register plus valid flag.
    - in_ready = ~prefetch_valid, taken from a register. No combinational out_ready->in_ready path.
    - A line accepted while DRAIN goes to prefetch.
    - On last-word transfer: prefetch moves to the line register with idx=0, staying DRAIN, and prefetch_valid clears unless a new line is accepted the same cycle.
    - Accepting while EMPTY loads the line register directly.
    - Reset clears prefetch_valid.
    - Ordering and throughput are the same as base.
  - Undefined: base behaviour above, with no prefetch storage.

Test Plan:
- Reset, then one line with word k = 0x1000+k (k=0..15) and out_ready=1 -> 16 words on consecutive cycles, values 0x1000..0x100F; out_last only on 0x100F; lines_done=1; then out_avail=0, in_ready=1.
- Two lines back-to-back (in_avail held, second line word k = 0x2000+k) with out_ready=1 -> 32 contiguous words with no gap; second line's in_ready high only in the cycle of 0x100F (base); lines_done=2.
- Same line with out_ready toggling 1,0,0,1,... -> out_data/out_last held across stalls; sequence still 0x1000..0x100F; no duplicates or drops.
- Assert reset after word 5 is accepted -> out_avail=0 immediately, lines_done=0; a next line 0xA5.. starts at word 0.
- Preload lines_done to 0xFFFFFFFF via 2^32-1 lines (or force), complete one line -> lines_done=0.
- With GENOMICS_UNPACK_PREFETCH_EN, out_ready=0 for 40 cycles with in_avail=1 -> exactly 2 lines accepted, then in_ready=0; releasing out_ready yields 32 ordered words.
